// File: rtl/mvm_rr_scheduler_pkg.sv
// Shared types and width helpers for the round-robin MVM scheduler.
// Widths are derived from the matrix geometry, so every user computes them the same way.
package mvm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_Y = 2'd2
  } sched_state_t;

  function automatic int w_bus_kx(input int r, input int c, input int w_x, input int w_k);
    return r * c * w_k + c * w_x;
  endfunction

  function automatic int w_y(input int c, input int w_x, input int w_k);
    return w_x + w_k + $clog2(c);
  endfunction

  function automatic int w_bus_y(input int r, input int c, input int w_x, input int w_k);
    return r * w_y(c, w_x, w_k);
  endfunction

  // A single requester still needs a 1-bit id so ports never collapse to zero width.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvm_rr_scheduler_if.sv
// Stream bundle between the requesters, the scheduler and the shared MVM.
// master = scheduler view, slave = view of the environment (requesters plus MVM).
interface mvm_rr_scheduler_if
  import mvm_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int W_BUS_KX = w_bus_kx(8, 8, 8, 8),
  parameter int W_BUS_Y  = w_bus_y(8, 8, 8, 8)
);
  logic [N_REQ-1:0]          s_axis_kx_tvalid;
  logic [N_REQ-1:0]          s_axis_kx_tready;
  logic [N_REQ*W_BUS_KX-1:0] s_axis_kx_tdata;
  logic [N_REQ-1:0]          m_axis_y_tvalid;
  logic [N_REQ-1:0]          m_axis_y_tready;
  logic [W_BUS_Y-1:0]        m_axis_y_tdata;
  logic                      mvm_kx_tvalid;
  logic                      mvm_kx_tready;
  logic [W_BUS_KX-1:0]       mvm_kx_tdata;
  logic                      mvm_y_tvalid;
  logic                      mvm_y_tready;
  logic [W_BUS_Y-1:0]        mvm_y_tdata;

  modport master (
    input  s_axis_kx_tvalid, s_axis_kx_tdata, m_axis_y_tready,
    input  mvm_kx_tready, mvm_y_tvalid, mvm_y_tdata,
    output s_axis_kx_tready, m_axis_y_tvalid, m_axis_y_tdata,
    output mvm_kx_tvalid, mvm_kx_tdata, mvm_y_tready
  );

  modport slave (
    output s_axis_kx_tvalid, s_axis_kx_tdata, m_axis_y_tready,
    output mvm_kx_tready, mvm_y_tvalid, mvm_y_tdata,
    input  s_axis_kx_tready, m_axis_y_tvalid, m_axis_y_tdata,
    input  mvm_kx_tvalid, mvm_kx_tdata, mvm_y_tready
  );

endinterface

// File: rtl/mvm_rr_scheduler_rr_pick.sv
// Combinational rotating-priority encoder: first set bit of req searching upward from last+1.
// Kept generic so other arbiters in the tree can reuse it.
module rr_pick #(
  parameter int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] gnt_id,
  output logic         any
);

  // Offset N wraps back to last itself, so the previous owner is considered only after everyone else.
  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!any && req[(int'(last) + i) % N]) begin
        any    = 1'b1;
        gnt_id = W'((int'(last) + i) % N);
      end
    end
  end

endmodule

// File: rtl/mvm_rr_scheduler.sv
// Round-robin scheduler sharing one axis_matvec_mul between N_REQ stream requesters; one job in flight.
// Optional MVM_SCHED_STATS_EN adds job_count, a 16-bit completed-job counter per requester.
module mvm_rr_scheduler
  import mvm_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int R     = 8,
  parameter int C     = 8,
  parameter int W_X   = 8,
  parameter int W_K   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  mvm_rr_scheduler_if.master        bus,
  output logic                      busy,
  output logic [id_w(N_REQ)-1:0]    grant_id
`ifdef MVM_SCHED_STATS_EN
  ,
  output logic [N_REQ*16-1:0]       job_count
`endif
);

  localparam int W_BUS_KX = w_bus_kx(R, C, W_X, W_K);
  localparam int W_ID     = id_w(N_REQ);

  sched_state_t     state_q, state_d;
  logic [W_ID-1:0]  grant_q, grant_d;
  logic [W_ID-1:0]  last_q, last_d;
  logic             busy_q, busy_d;

  logic [W_ID-1:0]  pick_id;
  logic             pick_any;
  logic [N_REQ-1:0] owner_mask;
  logic             in_issue;
  logic             in_wait;
  logic             kx_fire;
  logic             y_fire;

  rr_pick #(.N(N_REQ)) u_pick (
    .req    (bus.s_axis_kx_tvalid),
    .last   (last_q),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // Gating with rst makes the handshake lines drop in the very cycle reset is raised, not one later.
  assign in_issue   = (state_q == ISSUE) && !rst;
  assign in_wait    = (state_q == WAIT_Y) && !rst;
  assign owner_mask = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;

  assign bus.mvm_kx_tvalid    = in_issue && bus.s_axis_kx_tvalid[grant_q];
  assign bus.mvm_kx_tdata     = bus.s_axis_kx_tdata[int'(grant_q)*W_BUS_KX +: W_BUS_KX];
  assign bus.s_axis_kx_tready = in_issue ? (owner_mask & {N_REQ{bus.mvm_kx_tready}}) : '0;

  assign bus.m_axis_y_tvalid  = in_wait ? (owner_mask & {N_REQ{bus.mvm_y_tvalid}}) : '0;
  assign bus.mvm_y_tready     = in_wait && bus.m_axis_y_tready[grant_q];
  assign bus.m_axis_y_tdata   = bus.mvm_y_tdata;

  assign kx_fire = bus.mvm_kx_tvalid && bus.mvm_kx_tready;
  assign y_fire  = bus.mvm_y_tvalid && bus.mvm_y_tready;

  // last_q only advances on a completed result, so an aborted job does not cost its owner a turn.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_id;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (kx_fire) state_d = WAIT_Y;
      end
      WAIT_Y: begin
        if (y_fire) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= W_ID'(N_REQ - 1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign grant_id = grant_q;

`ifdef MVM_SCHED_STATS_EN
  logic [15:0] cnt_q [N_REQ];
  logic [15:0] cnt_d [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) cnt_d[i] = cnt_q[i];
    if (y_fire) cnt_d[grant_q] = cnt_q[grant_q] + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_job_count
    assign job_count[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_mvm_rr_scheduler.sv
// Directed self-checking bench for mvm_rr_scheduler with a small behavioural MVM behind it.
// Build with MVM_SCHED_STATS_EN defined to also exercise job_count.
module tb_mvm_rr_scheduler;
  import mvm_pkg::*;

  localparam int N_REQ    = 2;
  localparam int R        = 8;
  localparam int C        = 8;
  localparam int W_X      = 8;
  localparam int W_K      = 8;
  localparam int W_BUS_KX = w_bus_kx(R, C, W_X, W_K);
  localparam int W_Y      = w_y(C, W_X, W_K);
  localparam int W_BUS_Y  = w_bus_y(R, C, W_X, W_K);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic grant_id;
`ifdef MVM_SCHED_STATS_EN
  logic [N_REQ*16-1:0] job_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  mvm_rr_scheduler_if #(.N_REQ(N_REQ), .W_BUS_KX(W_BUS_KX), .W_BUS_Y(W_BUS_Y)) bus ();

  mvm_rr_scheduler #(.N_REQ(N_REQ), .R(R), .C(C), .W_X(W_X), .W_K(W_K)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
`ifdef MVM_SCHED_STATS_EN
    ,
    .job_count(job_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W_BUS_KX-1:0] make_kx(input int kval, input int xval);
    logic [W_BUS_KX-1:0] v;
    v = '0;
    for (int i = 0; i < R*C; i++) v[i*W_K +: W_K] = W_K'(kval);
    for (int c = 0; c < C; c++) v[R*C*W_K + c*W_X +: W_X] = W_X'(xval);
    return v;
  endfunction

  function automatic logic [W_BUS_Y-1:0] make_y(input int val);
    logic [W_BUS_Y-1:0] v;
    for (int r = 0; r < R; r++) v[r*W_Y +: W_Y] = W_Y'(val);
    return v;
  endfunction

  function automatic logic [W_BUS_Y-1:0] mvm_compute(input logic [W_BUS_KX-1:0] kx);
    logic [W_BUS_Y-1:0] v;
    logic [W_Y-1:0]     acc;
    for (int r = 0; r < R; r++) begin
      acc = '0;
      for (int c = 0; c < C; c++)
        acc = acc + W_Y'(kx[(r*C+c)*W_K +: W_K]) * W_Y'(kx[R*C*W_K + c*W_X +: W_X]);
      v[r*W_Y +: W_Y] = acc;
    end
    return v;
  endfunction

  // Behavioural MVM: accepts one job when idle, answers three cycles later.
  logic model_busy;
  int   model_delay;
  assign bus.mvm_kx_tready = !model_busy;

  always @(posedge clk) begin
    if (rst) begin
      model_busy       <= 1'b0;
      model_delay      <= 0;
      bus.mvm_y_tvalid <= 1'b0;
      bus.mvm_y_tdata  <= '0;
    end else begin
      if (bus.mvm_kx_tvalid && !model_busy) begin
        model_busy      <= 1'b1;
        model_delay     <= 2;
        bus.mvm_y_tdata <= mvm_compute(bus.mvm_kx_tdata);
      end else if (model_busy && !bus.mvm_y_tvalid) begin
        if (model_delay == 0) bus.mvm_y_tvalid <= 1'b1;
        else                  model_delay <= model_delay - 1;
      end
      if (bus.mvm_y_tvalid && bus.mvm_y_tready) begin
        bus.mvm_y_tvalid <= 1'b0;
        model_busy       <= 1'b0;
      end
    end
  end

  // Requester-side logs of every completed handshake.
  int                 kx_log[$];
  int                 y_id_log[$];
  logic [W_BUS_Y-1:0] y_data_log[$];
  int                 tready0_cycles  = 0;
  int                 mtvalid1_cycles = 0;

  always @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.s_axis_kx_tvalid[i] && bus.s_axis_kx_tready[i]) kx_log.push_back(i);
      if (bus.m_axis_y_tvalid[i] && bus.m_axis_y_tready[i]) begin
        y_id_log.push_back(i);
        y_data_log.push_back(bus.m_axis_y_tdata);
      end
    end
    if (bus.s_axis_kx_tready[0]) tready0_cycles++;
    if (bus.m_axis_y_tvalid[1])  mtvalid1_cycles++;
  end

  task automatic do_reset();
    @(negedge clk);
    bus.s_axis_kx_tvalid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_job(input int id, input int kval, input int xval, output bit ok);
    int kb, yb;
    kb = kx_log.size();
    yb = y_id_log.size();
    bus.s_axis_kx_tdata[id*W_BUS_KX +: W_BUS_KX] = make_kx(kval, xval);
    bus.m_axis_y_tready = '1;
    bus.s_axis_kx_tvalid[id] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (kx_log.size() > kb) bus.s_axis_kx_tvalid[id] = 1'b0;
      if (y_id_log.size() > yb) begin
        ok = 1'b1;
        break;
      end
    end
    bus.s_axis_kx_tvalid[id] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s_axis_kx_tvalid = '1;
    bus.m_axis_y_tready  = '0;
    bus.s_axis_kx_tdata  = '0;
    repeat (3) @(negedge clk);
    tests_run++; if (bus.s_axis_kx_tready !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_kx_tready got %b want 00", bus.s_axis_kx_tready); end
    tests_run++; if (bus.m_axis_y_tvalid !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_y_tvalid got %b want 00", bus.m_axis_y_tvalid); end
    tests_run++; if (bus.mvm_kx_tvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mvm_kx_tvalid got %b want 0", bus.mvm_kx_tvalid); end
    tests_run++; if (bus.mvm_y_tready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mvm_y_tready got %b want 0", bus.mvm_y_tready); end
    bus.s_axis_kx_tvalid = '0;
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (grant_id !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_grant_id got %0d want 0", grant_id); end
  endtask

  task automatic test_single_job();
    int kb, yb, p0, v1;
    bit ok;
    kb = kx_log.size(); yb = y_id_log.size();
    p0 = tready0_cycles; v1 = mtvalid1_cycles;
    run_job(0, 1, 1, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL single_done got timeout want completion"); end
    tests_run++; if (kx_log[kb] !== 0) begin tests_failed++; $display("[TB] FAIL single_grant got %0d want 0", kx_log[kb]); end
    tests_run++; if (tready0_cycles - p0 !== 1) begin tests_failed++; $display("[TB] FAIL single_tready_pulses got %0d want 1", tready0_cycles - p0); end
    tests_run++; if (y_id_log[yb] !== 0) begin tests_failed++; $display("[TB] FAIL single_y_dest got %0d want 0", y_id_log[yb]); end
    tests_run++; if (y_data_log[yb] !== make_y(8)) begin tests_failed++; $display("[TB] FAIL single_y_data got %h want %h", y_data_log[yb], make_y(8)); end
    tests_run++; if (mtvalid1_cycles - v1 !== 0) begin tests_failed++; $display("[TB] FAIL single_y1_quiet got %0d want 0", mtvalid1_cycles - v1); end
  endtask

  task automatic test_contention();
    int kb, yb;
    bit ok;
    do_reset();
    kb = kx_log.size(); yb = y_id_log.size();
    bus.s_axis_kx_tdata[0 +: W_BUS_KX]        = make_kx(1, 1);
    bus.s_axis_kx_tdata[W_BUS_KX +: W_BUS_KX] = make_kx(2, 1);
    bus.m_axis_y_tready  = '1;
    bus.s_axis_kx_tvalid = '1;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (y_id_log.size() >= yb + 4) begin
        ok = 1'b1;
        break;
      end
    end
    bus.s_axis_kx_tvalid = '0;
    repeat (2) @(negedge clk);
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL contention_done got timeout want 4 jobs"); end
    for (int j = 0; j < 4; j++) begin
      tests_run++; if (kx_log[kb+j] !== j % 2) begin tests_failed++; $display("[TB] FAIL contention_grant%0d got %0d want %0d", j, kx_log[kb+j], j % 2); end
      tests_run++; if (y_id_log[yb+j] !== j % 2) begin tests_failed++; $display("[TB] FAIL contention_dest%0d got %0d want %0d", j, y_id_log[yb+j], j % 2); end
      tests_run++; if (y_data_log[yb+j] !== make_y((j % 2 == 1) ? 16 : 8)) begin tests_failed++; $display("[TB] FAIL contention_data%0d got %h", j, y_data_log[yb+j]); end
    end
  endtask

  task automatic test_backpressure();
    int kb, yb, ytr_hi, t0_hi, busy_lo;
    bit hs, ok;
    kb = kx_log.size(); yb = y_id_log.size();
    bus.m_axis_y_tready = 2'b01;
    bus.s_axis_kx_tdata[W_BUS_KX +: W_BUS_KX] = make_kx(2, 1);
    bus.s_axis_kx_tvalid = 2'b10;
    hs = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (kx_log.size() > kb) begin hs = 1'b1; break; end
    end
    bus.s_axis_kx_tdata[0 +: W_BUS_KX] = make_kx(1, 1);
    bus.s_axis_kx_tvalid = 2'b01;
    ytr_hi = 0; t0_hi = 0; busy_lo = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.mvm_y_tready) ytr_hi++;
      if (bus.s_axis_kx_tready[0]) t0_hi++;
      if (!busy || grant_id !== 1'b1) busy_lo++;
    end
    tests_run++; if (!hs) begin tests_failed++; $display("[TB] FAIL bp_issue got timeout want handshake"); end
    tests_run++; if (ytr_hi !== 0) begin tests_failed++; $display("[TB] FAIL bp_mvm_y_tready got %0d cycles high want 0", ytr_hi); end
    tests_run++; if (t0_hi !== 0) begin tests_failed++; $display("[TB] FAIL bp_req0_tready got %0d cycles high want 0", t0_hi); end
    tests_run++; if (busy_lo !== 0) begin tests_failed++; $display("[TB] FAIL bp_held_owner got %0d bad cycles want 0", busy_lo); end
    tests_run++; if (bus.m_axis_y_tvalid !== 2'b10) begin tests_failed++; $display("[TB] FAIL bp_y_tvalid got %b want 10", bus.m_axis_y_tvalid); end
    bus.m_axis_y_tready = 2'b11;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (kx_log.size() > kb + 1) bus.s_axis_kx_tvalid = 2'b00;
      if (y_id_log.size() >= yb + 2) begin ok = 1'b1; break; end
    end
    bus.s_axis_kx_tvalid = 2'b00;
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL bp_release got timeout want 2 results"); end
    tests_run++; if (y_id_log[yb] !== 1) begin tests_failed++; $display("[TB] FAIL bp_y_dest got %0d want 1", y_id_log[yb]); end
    tests_run++; if (y_data_log[yb] !== make_y(16)) begin tests_failed++; $display("[TB] FAIL bp_y_data got %h want %h", y_data_log[yb], make_y(16)); end
    tests_run++; if (kx_log[kb+1] !== 0) begin tests_failed++; $display("[TB] FAIL bp_next_grant got %0d want 0", kx_log[kb+1]); end
  endtask

  task automatic test_reset_mid_job();
    int kb, yb;
    bit hs, ok;
    kb = kx_log.size();
    bus.m_axis_y_tready = 2'b00;
    bus.s_axis_kx_tdata[W_BUS_KX +: W_BUS_KX] = make_kx(2, 1);
    bus.s_axis_kx_tvalid = 2'b10;
    hs = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (kx_log.size() > kb) begin hs = 1'b1; break; end
    end
    bus.s_axis_kx_tvalid = 2'b00;
    repeat (6) @(negedge clk);
    tests_run++; if (!hs) begin tests_failed++; $display("[TB] FAIL mid_issue got timeout want handshake"); end
    tests_run++; if (bus.m_axis_y_tvalid !== 2'b10) begin tests_failed++; $display("[TB] FAIL mid_pre_y_tvalid got %b want 10", bus.m_axis_y_tvalid); end
    rst = 1'b1;
    #1;
    tests_run++; if (bus.m_axis_y_tvalid !== 2'b00) begin tests_failed++; $display("[TB] FAIL mid_y_drop got %b want 00", bus.m_axis_y_tvalid); end
    @(negedge clk);
    rst = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_busy got %b want 0", busy); end
    tests_run++; if (grant_id !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_grant_id got %0d want 0", grant_id); end
    tests_run++; if (bus.m_axis_y_tvalid !== 2'b00 || bus.mvm_kx_tvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_outputs got y_tvalid=%b kx_tvalid=%b want 0", bus.m_axis_y_tvalid, bus.mvm_kx_tvalid); end
    kb = kx_log.size(); yb = y_id_log.size();
    bus.s_axis_kx_tdata[0 +: W_BUS_KX] = make_kx(1, 1);
    bus.m_axis_y_tready  = 2'b11;
    bus.s_axis_kx_tvalid = 2'b11;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (kx_log.size() > kb) bus.s_axis_kx_tvalid = 2'b00;
      if (y_id_log.size() > yb) begin ok = 1'b1; break; end
    end
    bus.s_axis_kx_tvalid = 2'b00;
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL mid_after_done got timeout want completion"); end
    tests_run++; if (kx_log[kb] !== 0) begin tests_failed++; $display("[TB] FAIL mid_first_grant got %0d want 0", kx_log[kb]); end
    tests_run++; if (y_id_log[yb] !== 0) begin tests_failed++; $display("[TB] FAIL mid_y_dest got %0d want 0", y_id_log[yb]); end
  endtask

`ifdef MVM_SCHED_STATS_EN
  task automatic test_stats();
    bit ok, all_ok;
    do_reset();
    tests_run++; if (job_count !== 32'd0) begin tests_failed++; $display("[TB] FAIL stats_reset got %h want 0", job_count); end
    all_ok = 1'b1;
    for (int j = 0; j < 5; j++) begin
      run_job((j < 3) ? 0 : 1, 1, 1, ok);
      all_ok = all_ok && ok;
    end
    tests_run++; if (!all_ok) begin tests_failed++; $display("[TB] FAIL stats_jobs got timeout want 5 completions"); end
    tests_run++; if (job_count !== {16'd2, 16'd3}) begin tests_failed++; $display("[TB] FAIL stats_count got %h want %h", job_count, {16'd2, 16'd3}); end
  endtask
`endif

  initial begin
    bus.s_axis_kx_tvalid = '0;
    bus.s_axis_kx_tdata  = '0;
    bus.m_axis_y_tready  = '0;
    test_reset();
    test_single_job();
    test_contention();
    test_backpressure();
    test_reset_mid_job();
`ifdef MVM_SCHED_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
